mem_port_arbiter: RTL and testbench

- Shares one 32-bit memory port between two requesters with a round-robin scheme: requester 0 is instruction fetch, requester 1 is load/store.
- Captures the winning request, issues it to memory with a valid/ready handshake, and routes the response back to its owner.
- Drives `sel`, the select of the 32-bit 2:1 address/data multiplexer in front of the memory. 0 picks requester 0, 1 picks requester 1.
- Only one transaction is outstanding at a time.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch (0) and load/store (1).
// Define ARB_TIMEOUT_EN to add a response watchdog that returns err=1 and 32'hDEAD_BEEF.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          sel,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  // state   | meaning
  // S_IDLE  | no transaction; arbitrate and grant in the same cycle
  // S_ISSUE | mem_req high with the latched command until mem_ready
  // S_WAIT  | command accepted, waiting for mem_rvalid
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic win;
  logic grant;
  logic busy;
  logic resp;
  logic timeout;

  // On a tie the requester that did not win last time takes the port.
  assign win   = (req0 && req1) ? ~last_q : req1;
  assign grant = (state_q == S_IDLE) && (req0 || req1) && !rst;
  assign busy  = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign resp  = mem_rvalid && (((state_q == S_ISSUE) && mem_ready) || (state_q == S_WAIT));

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Down-counter loaded at grant; terminal count means TIMEOUT cycles spent in ISSUE/WAIT.
  assign timeout = busy && (tmo_q == '0) && !resp;

  always_comb begin
    tmo_d = tmo_q;
    err_d = timeout;
    if (grant) begin
      tmo_d = TW'(TIMEOUT);
    end else if (busy && (tmo_q != '0)) begin
      tmo_d = tmo_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    gnt0      = grant && !win;
    gnt1      = grant && win;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_ISSUE;
          last_d  = win;
          sel_d   = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A response (or watchdog expiry) always ends the transaction, even straight from ISSUE.
    if (resp || timeout) begin
      state_d   = S_IDLE;
      rvalid0_d = ~sel_q;
      rvalid1_d = sel_q;
      rdata_d   = timeout ? DW'(32'hDEAD_BEEF) : mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign sel       = sel_q;
  assign rdata     = rdata_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected responses are queued at grant and matched on rvalid.
module tb_mem_port_arbiter;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, gnt0, rvalid0;
  logic [31:0] addr0, wdata0;
  logic        req1, we1, gnt1, rvalid1;
  logic [31:0] addr1, wdata1;
  logic [31:0] rdata;
  logic        err, sel;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .err(err), .sel(sel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   rv_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic o, input logic w, input logic e, input logic [31:0] d);
    exp_t x;
    x.owner = o;
    x.we    = w;
    x.err   = e;
    x.data  = d;
    sb_q.push_back(x);
  endtask

  task automatic mon();
    exp_t x;
    rv_seen = 0;
    if (rvalid0 || rvalid1) begin
      rv_seen = 1;
      if (sb_q.size() == 0) begin
        chk("unexpected_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
      end else begin
        x = sb_q.pop_front();
        chk("rv_owner", {30'b0, rvalid1, rvalid0}, x.owner ? 32'd2 : 32'd1);
        chk("rv_err", {31'b0, err}, {31'b0, x.err});
        if (!x.we) chk("rv_rdata", rdata, x.data);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    mon();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic        w;
    logic [31:0] ea;
    int          n0;
    int          n1;
    int          cyc_n;
    n0 = 0;
    n1 = 0;
    cyc_n = 0;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset, then idle
    adv(); smp();
    adv(); smp();
    adv(); rst = 1'b0; smp();
    chk("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    chk("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_sel", {31'b0, sel}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_cmd", {31'b0, mem_we} | mem_addr | mem_wdata, 32'd0);

    // both requesters held, immediate responses: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      adv();
      if (i == 0) begin
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h2000; addr1 = 32'h3000;
        mem_ready = 1'b1; mem_rvalid = 1'b1;
      end
      smp();
      w = (i % 2) == 1;
      chk("rr_gnt", {30'b0, gnt1, gnt0}, w ? 32'd2 : 32'd1);
      ea = w ? addr1 : addr0;
      push_exp(w, 1'b0, 1'b0, 32'hA5A5_0000 + 32'(i));
      adv();
      mem_rdata = 32'hA5A5_0000 + 32'(i);
      if (w) begin n1++; addr1 = 32'h3000 + 32'(n1); end
      else   begin n0++; addr0 = 32'h2000 + 32'(n0); end
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      smp();
      chk("rr_sel", {31'b0, sel}, {31'b0, w});
      chk("rr_mem_req", {31'b0, mem_req}, 32'd1);
      chk("rr_addr", mem_addr, ea);
    end
    adv(); mem_ready = 1'b0; mem_rvalid = 1'b0; smp();
    chk("rr_last_rv", rv_seen, 32'd1);
    chk("rr_no_gnt", {30'b0, gnt1, gnt0}, 32'd0);

    // req0 read, memory answers one cycle after mem_ready
    adv(); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = '0; smp();
    chk("t1_gnt", {30'b0, gnt1, gnt0}, 32'd1);
    push_exp(1'b0, 1'b0, 1'b0, 32'h1234_5678);
    adv(); req0 = 1'b0; addr0 = '0; mem_ready = 1'b1; smp();
    chk("t1_mem_req", {31'b0, mem_req}, 32'd1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_we", {31'b0, mem_we}, 32'd0);
    chk("t1_sel", {31'b0, sel}, 32'd0);
    adv(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; smp();
    chk("t1_wait_req", {31'b0, mem_req}, 32'd0);
    chk("t1_early_rv", rv_seen, 32'd0);
    adv(); mem_rvalid = 1'b0; mem_rdata = '0; smp();
    chk("t1_rvalid0", {31'b0, rvalid0}, 32'd1);
    chk("t1_rdata", rdata, 32'h1234_5678);
    adv(); smp();
    chk("t1_rv_pulse", {30'b0, rvalid1, rvalid0}, 32'd0);
    chk("t1_rdata_hold", rdata, 32'h1234_5678);

    // req1 write with mem_ready held low for 4 cycles
    adv(); req1 = 1'b1; we1 = 1'b1; addr1 = 32'h100; wdata1 = 32'hCAFE_F00D; smp();
    chk("t3_gnt", {30'b0, gnt1, gnt0}, 32'd2);
    push_exp(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      adv();
      if (k == 1) begin req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; end
      mem_ready = (k == 5);
      smp();
      chk("t3_mem_req", {31'b0, mem_req}, 32'd1);
      chk("t3_addr", mem_addr, 32'h100);
      chk("t3_wdata", mem_wdata, 32'hCAFE_F00D);
      chk("t3_we", {31'b0, mem_we}, 32'd1);
    end
    adv(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD; smp();
    chk("t3_wait_req", {31'b0, mem_req}, 32'd0);
    chk("t3_early_rv", rv_seen, 32'd0);
    adv(); mem_rvalid = 1'b0; smp();
    chk("t3_rvalid1", {30'b0, rvalid1, rvalid0}, 32'd2);
    adv(); smp();
    chk("t3_sel_hold", {31'b0, sel}, 32'd1);

    // reset while in WAIT drops the transaction
    adv(); req0 = 1'b1; addr0 = 32'h40; smp();
    chk("t4_gnt", {30'b0, gnt1, gnt0}, 32'd1);
    adv(); req0 = 1'b0; mem_ready = 1'b1; smp();
    chk("t4_issue", {31'b0, mem_req}, 32'd1);
    adv(); mem_ready = 1'b0; smp();
    chk("t4_wait", {31'b0, mem_req}, 32'd0);
    adv(); rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000; smp();
    adv(); rst = 1'b0; mem_rvalid = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h44; addr1 = 32'h144; smp();
    chk("t4_mem_req", {31'b0, mem_req}, 32'd0);
    chk("t4_no_rv", rv_seen, 32'd0);
    chk("t4_sel", {31'b0, sel}, 32'd0);
    chk("t4_tie_gnt", {30'b0, gnt1, gnt0}, 32'd1);
    push_exp(1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
    adv(); req0 = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA; smp();
    chk("t4_addr", mem_addr, 32'h44);
    adv(); mem_ready = 1'b0; mem_rvalid = 1'b0; smp();
    chk("t4_rvalid0", {31'b0, rvalid0}, 32'd1);
    chk("t4_gnt_with_rv", {30'b0, gnt1, gnt0}, 32'd2);
    push_exp(1'b1, 1'b0, 1'b0, 32'h7777_7777);
    adv(); req1 = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777; smp();
    chk("t4_addr1", mem_addr, 32'h144);
    adv(); mem_ready = 1'b0; mem_rvalid = 1'b0; smp();
    chk("t4_rvalid1", {31'b0, rvalid1}, 32'd1);

`ifdef ARB_TIMEOUT_EN
    // memory never answers: watchdog response after TMO cycles in ISSUE/WAIT
    adv(); req0 = 1'b1; addr0 = 32'h80; smp();
    chk("to_gnt", {30'b0, gnt1, gnt0}, 32'd1);
    push_exp(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    adv(); req0 = 1'b0; mem_ready = 1'b1; smp();
    adv(); mem_ready = 1'b0; smp();
    cyc_n = 2;
    while (rv_seen == 0 && cyc_n < TMO + 10) begin
      adv(); smp();
      cyc_n++;
    end
    chk("to_seen", rv_seen, 32'd1);
    chk("to_latency", cyc_n, TMO + 2);
    adv(); mem_rvalid = 1'b1; mem_rdata = 32'h1; smp();
    adv(); mem_rvalid = 1'b0; smp();
    chk("to_late_ignored", rv_seen, 32'd0);
    chk("to_idle", {31'b0, mem_req}, 32'd0);
`endif

    repeat (3) begin adv(); smp(); end
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
